// File: rtl/tdr_pkg.sv
// tdr_pkg: shared state type and default sizes for the TDR echo timer
package tdr_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, ARMED, DONE} tdr_timer_state_t;
  localparam int TDR_CNT_W_DEFAULT = 16;
  localparam int TDR_MAX_WINDOW_DEFAULT = 4095;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: STAGES-deep flop chain synchronizing an asynchronous bit into clk, sync active-high reset
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk)
    if (rst) sync_q <= '0;
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/tdr_echo_timer.sv
// tdr_echo_timer: launch-to-first-echo-edge time-of-flight timer with blanking, timeout and valid/ready result; define TDR_ECHO_DEGLITCH_EN to require a 2-cycle echo
module tdr_echo_timer
  import tdr_pkg::*;
#(
  parameter int CNT_W        = TDR_CNT_W_DEFAULT,
  parameter int MAX_WINDOW   = TDR_MAX_WINDOW_DEFAULT,
  parameter int BLANK_CYCLES = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             echo_in,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] tof_count,
  output logic             timeout,
  output logic             pulse_overrun
);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WINDOW);
  tdr_timer_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, tof_q, tof_d;
  logic timeout_q, timeout_d, busy_q, busy_d, valid_q, valid_d, overrun_q, overrun_d;
  logic sync_q, hist_q, hist_d, echo_edge;
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(echo_in), .q(sync_q));
`ifdef TDR_ECHO_DEGLITCH_EN
  logic hist2_q, hist2_d;
  assign echo_edge = sync_q & hist_q & ~hist2_q;
`else
  assign echo_edge = sync_q & ~hist_q;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    tof_d = tof_q;
    timeout_d = timeout_q;
    hist_d = sync_q;
`ifdef TDR_ECHO_DEGLITCH_EN
    hist2_d = hist_q;
`endif
    overrun_d = pulse_in & (state_q != IDLE);
    case (state_q)
      IDLE: if (pulse_in) begin
        cnt_d = '0;
        state_d = BLANK;
      end
      BLANK: begin
        cnt_d = cnt_q + CNT_W'(1);
        state_d = (cnt_q == BLANK_LAST) ? ARMED : BLANK;
      end
      ARMED: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (echo_edge) begin
          tof_d = cnt_q;
          timeout_d = 1'b0;
          state_d = DONE;
        end else if (cnt_q == MAX_CNT) begin
          tof_d = MAX_CNT;
          timeout_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = result_ready ? IDLE : DONE;
    endcase
    busy_d = state_d != IDLE;
    valid_d = state_d == DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tof_q <= '0;
      timeout_q <= 1'b0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      overrun_q <= 1'b0;
      hist_q <= 1'b0;
`ifdef TDR_ECHO_DEGLITCH_EN
      hist2_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tof_q <= tof_d;
      timeout_q <= timeout_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
      overrun_q <= overrun_d;
      hist_q <= hist_d;
`ifdef TDR_ECHO_DEGLITCH_EN
      hist2_q <= hist2_d;
`endif
    end
  assign busy = busy_q;
  assign result_valid = valid_q;
  assign tof_count = tof_q;
  assign timeout = timeout_q;
  assign pulse_overrun = overrun_q;
endmodule

// File: tb/tb_tdr_echo_timer.sv
// tb_tdr_echo_timer: table-driven directed bench for tdr_echo_timer (MAX_WINDOW=100, BLANK_CYCLES=4, SYNC_STAGES=2)
module tb_tdr_echo_timer;
  localparam int NONE = 100000;
`ifdef TDR_ECHO_DEGLITCH_EN
  localparam int DG = 1;
`else
  localparam int DG = 0;
`endif
  typedef struct {
    int e1s;
    int e1l;
    int e2s;
    int tof;
    int to;
    int lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pulse_in = 1'b0;
  logic echo_in = 1'b0;
  logic result_ready = 1'b0;
  logic busy, result_valid, timeout, pulse_overrun;
  logic [15:0] tof_count;
  vec_t vecs[9];
  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  always #5 clk = ~clk;
  tdr_echo_timer #(.CNT_W(16), .MAX_WINDOW(100), .BLANK_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .pulse_in(pulse_in),
    .echo_in(echo_in),
    .busy(busy),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .tof_count(tof_count),
    .timeout(timeout),
    .pulse_overrun(pulse_overrun)
  );
  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic p, input logic e, input logic r, input logic rs);
    @(posedge clk);
    #1;
    pulse_in = p;
    echo_in = e;
    result_ready = r;
    rst = rs;
    @(negedge clk);
  endtask
  function automatic logic echo_at(input vec_t v, input int c);
    return (c >= v.e1s && c < v.e1s + v.e1l) || c >= v.e2s;
  endfunction
  task automatic measure(input vec_t v, output int l);
    l = -1;
    for (int c = -4; c < 400 && l < 0; c++) begin
      cyc(c == 0, echo_at(v, c), 1'b0, 1'b0);
      if (c == 1) check("busy_after_pulse", busy, 1);
      if (result_valid) l = c;
    end
    if (l < 0) check("valid_within_budget", 0, 1);
  endtask
  task automatic accept();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("valid_before_transfer", result_valid, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("valid_after_transfer", result_valid, 0);
    check("busy_after_transfer", busy, 0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{NONE, 0, 20, 21 + DG, 0, 23 + DG};
    vecs[1] = '{1, 2, 30, 31 + DG, 0, 33 + DG};
    vecs[2] = '{NONE, 0, NONE, 100, 1, 102};
    vecs[3] = '{NONE, 0, -4, 100, 1, 102};
    vecs[4] = '{20, 1, 40, DG ? 42 : 21, 0, DG ? 44 : 23};
    vecs[5] = '{NONE, 0, 3, 4 + DG, 0, 6 + DG};
    vecs[6] = '{NONE, 0, 2, DG ? 4 : 100, DG ? 0 : 1, DG ? 6 : 102};
    vecs[7] = '{NONE, 0, 99 - DG, 100, 0, 102};
    vecs[8] = '{NONE, 0, 100 - DG, 100, 1, 102};
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_tof", tof_count, 0);
    check("rst_timeout", timeout, 0);
    check("rst_overrun", pulse_overrun, 0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      measure(vecs[i], lat);
      check($sformatf("vec%0d_tof", i), tof_count, vecs[i].tof);
      check($sformatf("vec%0d_timeout", i), timeout, vecs[i].to);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      accept();
    end
    measure(vecs[0], lat);
    check("bp_tof", tof_count, 21 + DG);
    for (int i = 0; i < 10; i++) begin
      cyc(i == 3, 1'b0, 1'b0, 1'b0);
      check("bp_valid_held", result_valid, 1);
      check("bp_tof_held", tof_count, 21 + DG);
      check("bp_overrun", pulse_overrun, int'(i == 4));
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("bp_valid_in_transfer", result_valid, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_valid_after", result_valid, 0);
    check("bp_busy_after", busy, 0);
    check("bp_overrun_transfer", pulse_overrun, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_overrun_clear", pulse_overrun, 0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    measure(vecs[0], lat);
    check("bp_next_tof", tof_count, 21 + DG);
    check("bp_next_latency", lat, 23 + DG);
    accept();
    for (int c = 0; c <= 50; c++) cyc(c == 0, 1'b0, 1'b0, 1'b0);
    check("mid_busy_before", busy, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_tof", tof_count, 0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    measure(vecs[0], lat);
    check("post_rst_tof", tof_count, 21 + DG);
    check("post_rst_timeout", timeout, 0);
    accept();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
